// File: rtl/cpu_run_pkg.sv
// Shared types and helpers for the CPU run controller.
// Holds the run-state enum, signature width and the signature step function.
package cpu_run_pkg;

    localparam int SIG_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } run_state_t;

    // Rotate left by one, then fold in the new write word.
    function automatic logic [SIG_W-1:0] sig_step(
        input logic [SIG_W-1:0] sig,
        input logic [SIG_W-1:0] val
    );
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ val;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Harness-side bundle for the run controller.
// master: harness drives start/fetch/RAM, slave: controller drives status.
interface cpu_run_ctrl_if #(
    parameter int INS_W      = 16,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int MAX_CYCLES = 70
);
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    logic              start;
    logic [INS_W-1:0]  ins;
    logic              ins_valid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  wr_count;
    logic [ADDR_W-1:0] last_wr_addr;
    logic [DATA_W-1:0] last_wr_data;
    logic [31:0]       signature;

    modport master (
        output start, ins, ins_valid, ram_en, ram_we, ram_addr, ram_wdata,
        input  cpu_rst_n, busy, done, timeout, cycle_count, wr_count,
        input  last_wr_addr, last_wr_data, signature
    );

    modport slave (
        input  start, ins, ins_valid, ram_en, ram_we, ram_addr, ram_wdata,
        output cpu_rst_n, busy, done, timeout, cycle_count, wr_count,
        output last_wr_addr, last_wr_data, signature
    );

endinterface

// File: rtl/cpu_run_sig.sv
// Rotate-XOR accumulator over captured RAM writes {addr, data}.
// Ports: clk, rst (async high), clr, en, addr, data in; sig out.
module cpu_run_sig
    import cpu_run_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] w_val;
    logic [SIG_W-1:0] r_sig;

    assign w_val = SIG_W'({addr, data});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= sig_step(r_sig, w_val);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences CPU reset, counts RUN cycles, ends on halt/budget.
// Ports: clk, rst (async high), bus (slave). Macro CPU_RUN_SIG_EN builds signature.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int              INS_W      = 16,
    parameter int              OP_W       = 4,
    parameter logic [OP_W-1:0] HALT_OP    = 4'hF,
    parameter int              ADDR_W     = 5,
    parameter int              DATA_W     = 8,
    parameter int              RST_CYCLES = 3,
    parameter int              MAX_CYCLES = 70
) (
    input  logic         clk,
    input  logic         rst,
    cpu_run_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t        r_state;
    run_state_t        w_next;
    logic              w_clr;
    logic              w_cap;
    logic              w_halt;
    logic              w_budget;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_wr_count;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_last_data;
    logic              r_timeout;
    logic              r_cpu_rst_n;
    logic              r_busy;
    logic              r_done;

    assign w_halt   = bus.ins_valid &&
                      (bus.ins[INS_W-1 -: OP_W] == HALT_OP);
    assign w_budget = (r_cycle_count == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_cap  = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_next = ST_RESET;
                    w_clr  = 1'b1;
                end
            end
            ST_RESET: begin
                if (r_rst_cnt == '0) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cap = bus.ram_en && bus.ram_we;
                if (w_halt || w_budget) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Status outputs register the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cpu_rst_n <= (w_next == ST_RUN);
            r_busy      <= (w_next == ST_RESET) || (w_next == ST_RUN);
            r_done      <= (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_wr_count    <= '0;
            r_last_addr   <= '0;
            r_last_data   <= '0;
            r_timeout     <= 1'b0;
        end else if (w_clr) begin
            r_rst_cnt     <= RC_W'(RST_CYCLES - 1);
            r_cycle_count <= '0;
            r_wr_count    <= '0;
            r_last_addr   <= '0;
            r_last_data   <= '0;
            r_timeout     <= 1'b0;
        end else begin
            if (r_state == ST_RESET && r_rst_cnt != '0) begin
                r_rst_cnt <= r_rst_cnt - 1'b1;
            end
            if (r_state == ST_RUN) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            // Halt has priority over the budget on the exit cycle.
            if (r_state == ST_RUN && w_next == ST_DONE) begin
                r_timeout <= !w_halt;
            end
            if (w_cap) begin
                if (r_wr_count != '1) begin
                    r_wr_count <= r_wr_count + 1'b1;
                end
                r_last_addr <= bus.ram_addr;
                r_last_data <= bus.ram_wdata;
            end
        end
    end

    assign bus.cpu_rst_n    = r_cpu_rst_n;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.timeout      = r_timeout;
    assign bus.cycle_count  = r_cycle_count;
    assign bus.wr_count     = r_wr_count;
    assign bus.last_wr_addr = r_last_addr;
    assign bus.last_wr_data = r_last_data;

`ifdef CPU_RUN_SIG_EN
    logic [SIG_W-1:0] w_sig;

    cpu_run_sig #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sig (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_cap),
        .addr (bus.ram_addr),
        .data (bus.ram_wdata),
        .sig  (w_sig)
    );

    assign bus.signature = w_sig;
`else
    assign bus.signature = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a queue scoreboard.
// Covers reset, start timing, timeout, halt, write capture, mid-run reset.
module tb_cpu_run_ctrl;

    logic clk;
    logic rst;

    cpu_run_ctrl_if #(
        .INS_W      (16),
        .ADDR_W     (5),
        .DATA_W     (8),
        .MAX_CYCLES (70)
    ) bus ();

    cpu_run_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef CPU_RUN_SIG_EN
    localparam logic [31:0] SIG_A = 32'h000002B5;
    localparam logic [31:0] SIG_B = 32'h00001FFF;
`else
    localparam logic [31:0] SIG_A = 32'h0;
    localparam logic [31:0] SIG_B = 32'h0;
`endif

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        assert (q.size() != 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                n_bad++;
                $error("FAIL %s observed=%0h expected=%0h",
                       e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start     = 1'b0;
        bus.ins       = 16'h0000;
        bus.ins_valid = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = 5'd0;
        bus.ram_wdata = 8'h00;
    endtask

    // Pulse start and step to the first RUN edge (edge 4).
    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        tick();

        push("rst_cpu_rst_n", 0); chk(32'(bus.cpu_rst_n));
        push("rst_busy", 0);      chk(32'(bus.busy));
        push("rst_done", 0);      chk(32'(bus.done));
        push("rst_timeout", 0);   chk(32'(bus.timeout));
        push("rst_cycles", 0);    chk(32'(bus.cycle_count));
        push("rst_wr", 0);        chk(32'(bus.wr_count));
        push("rst_sig", 0);       chk(bus.signature);

        rst = 1'b0;
        tick();
        tick();
        push("idle_busy", 0);     chk(32'(bus.busy));
        push("idle_done", 0);     chk(32'(bus.done));

        // Start sequence timing.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        push("e1_busy", 1);       chk(32'(bus.busy));
        push("e1_cpu_rst_n", 0);  chk(32'(bus.cpu_rst_n));
        tick();
        push("e2_cpu_rst_n", 0);  chk(32'(bus.cpu_rst_n));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        push("e3_cpu_rst_n", 0);  chk(32'(bus.cpu_rst_n));
        tick();
        push("e4_cpu_rst_n", 1);  chk(32'(bus.cpu_rst_n));
        push("e4_cycles", 0);     chk(32'(bus.cycle_count));

        // Timeout: no halt fetched.
        for (int i = 0; i < 69; i++) tick();
        push("to_pre_done", 0);   chk(32'(bus.done));
        push("to_pre_cycles", 69); chk(32'(bus.cycle_count));
        tick();
        push("to_done", 1);       chk(32'(bus.done));
        push("to_timeout", 1);    chk(32'(bus.timeout));
        push("to_cycles", 70);    chk(32'(bus.cycle_count));
        push("to_cpu_rst_n", 0);  chk(32'(bus.cpu_rst_n));
        push("to_busy", 0);       chk(32'(bus.busy));
        tick();
        tick();
        push("hold_done", 1);     chk(32'(bus.done));
        push("hold_cycles", 70);  chk(32'(bus.cycle_count));

        // Halt on RUN cycle 10 with two writes and ignored traffic.
        push("h_clr_cycles", 0);
        push("h_clr_timeout", 0);
        push("h_done", 1);
        push("h_timeout", 0);
        push("h_cycles", 10);
        push("h_wr", 2);
        push("h_addr", 4);
        push("h_data", 32'h01);
        push("h_sig", SIG_A);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk(32'(bus.cycle_count));
        chk(32'(bus.timeout));
        tick();
        tick();
        tick();
        for (int c = 1; c <= 10; c++) begin
            idle_in();
            if (c == 2) begin
                bus.ins       = 16'hE000;
                bus.ins_valid = 1'b1;
                bus.start     = 1'b1;
            end
            if (c == 3) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = 5'd3;
                bus.ram_wdata = 8'h5A;
            end
            if (c == 4) bus.ins = 16'hF000;
            if (c == 5) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = 5'd4;
                bus.ram_wdata = 8'h01;
            end
            if (c == 6) begin
                bus.ram_we    = 1'b1;
                bus.ram_addr  = 5'd9;
                bus.ram_wdata = 8'hCC;
            end
            if (c == 10) begin
                bus.ins       = 16'hF000;
                bus.ins_valid = 1'b1;
            end
            tick();
        end
        idle_in();
        chk(32'(bus.done));
        chk(32'(bus.timeout));
        chk(32'(bus.cycle_count));
        chk(32'(bus.wr_count));
        chk(32'(bus.last_wr_addr));
        chk(32'(bus.last_wr_data));
        chk(bus.signature);

        // Halt and budget together, with a write on the exit cycle.
        push("hb_done", 1);
        push("hb_timeout", 0);
        push("hb_cycles", 70);
        push("hb_wr", 1);
        push("hb_addr", 31);
        push("hb_data", 32'hFF);
        push("hb_sig", SIG_B);
        start_run();
        for (int i = 0; i < 69; i++) tick();
        bus.ins       = 16'hF123;
        bus.ins_valid = 1'b1;
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = 5'd31;
        bus.ram_wdata = 8'hFF;
        tick();
        idle_in();
        chk(32'(bus.done));
        chk(32'(bus.timeout));
        chk(32'(bus.cycle_count));
        chk(32'(bus.wr_count));
        chk(32'(bus.last_wr_addr));
        chk(32'(bus.last_wr_data));
        chk(bus.signature);

        // Mid-run reset on RUN cycle 5, then a clean restart.
        start_run();
        bus.ram_en = 1'b1;
        bus.ram_we = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle_in();
        push("mr_pre_cycles", 4); chk(32'(bus.cycle_count));
        rst = 1'b1;
        #1;
        push("mr_cpu_rst_n", 0);  chk(32'(bus.cpu_rst_n));
        push("mr_busy", 0);       chk(32'(bus.busy));
        push("mr_cycles", 0);     chk(32'(bus.cycle_count));
        push("mr_wr", 0);         chk(32'(bus.wr_count));
        tick();
        rst = 1'b0;
        tick();
        push("mr_idle_busy", 0);  chk(32'(bus.busy));
        start_run();
        push("rs_cpu_rst_n", 1);  chk(32'(bus.cpu_rst_n));
        push("rs_cycles0", 0);    chk(32'(bus.cycle_count));
        tick();
        tick();
        tick();
        push("rs_cycles3", 3);    chk(32'(bus.cycle_count));
        push("rs_done", 0);       chk(32'(bus.done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller and monitor for `top_cpu`. It sequences the CPU reset, counts execution cycles, and detects a halt instruction or a cycle-budget timeout. It also captures RAM write activity into counters and an optional signature. It sits beside `top_cpu` in the sim/FPGA harness, replacing fixed-delay testbench stimulus with a parametrised, self-terminating run.

## Interface
Parameters:
- `INS_W`, 16, instruction width
- `OP_W`, 4, opcode field width; the opcode is `ins[INS_W-1 -: OP_W]`
- `HALT_OP`, 4'hF, opcode that ends a run
- `ADDR_W`, 5, RAM address width
- `DATA_W`, 8, RAM data width
- `RST_CYCLES`, 3, CPU reset hold length in cycles (≥1)
- `MAX_CYCLES`, 70, run-cycle budget (≥2)

Ports (`CNT_W = $clog2(MAX_CYCLES+1)`):
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that starts a run
- `ins`  in  INS_W  instruction currently fetched by the CPU
- `ins_valid`  in  1  `ins` is a valid fetch this cycle
- `ram_en`, `ram_we`  in  1 each  CPU RAM enable and write enable
- `ram_addr`  in  ADDR_W  RAM address
- `ram_wdata`  in  DATA_W  RAM write data
- `cpu_rst_n`  out  1  CPU reset, active-low; high only in RUN
- `busy`  out  1  high in RESET or RUN
- `done`  out  1  high in DONE
- `timeout`  out  1  the run ended on the budget, not on a halt
- `cycle_count`  out  CNT_W  RUN cycles elapsed
- `wr_count`  out  CNT_W  RAM writes seen; saturates at all-ones
- `last_wr_addr`  out  ADDR_W  address of the most recent write
- `last_wr_data`  out  DATA_W  data of the most recent write
- `signature`  out  32  write signature (see Configuration)

## Operation
- States: IDLE, RESET, RUN, DONE.
- **IDLE → RESET:** on `start`. The same cycle clears `cycle_count`, `wr_count`, `last_wr_*`, `signature` and `timeout`, and loads the reset counter.
- **RESET → RUN:** after exactly `RST_CYCLES` cycles in RESET.
- **RUN, every cycle:** `cycle_count` increments.
- **RUN, write capture:** when `ram_en && ram_we`, update `wr_count`, `last_wr_*` and `signature`.
- **RUN → DONE on halt:** when `ins_valid` is set and the opcode equals `HALT_OP`; `timeout` = 0.
- **RUN → DONE on budget:** when `cycle_count == MAX_CYCLES-1` and no halt that cycle; `timeout` = 1.
- **Halt and budget in the same cycle:** halt wins; `timeout` = 0.
- **Write on the exit cycle:** captured.
- **DONE → RESET:** on `start`, which restarts the run. In DONE the outputs hold and the CPU is frozen in reset.
- **`start` in RESET or RUN:** ignored.

## Timing
- **Reset values:** asserting `rst` immediately forces IDLE. Then `cpu_rst_n` = 0, `busy` = 0, `done` = 0, `timeout` = 0, and every counter, capture register and `signature` = 0. This also applies mid-run.
- **Start sequence:** with `start` sampled at edge 0, `cpu_rst_n` is low from edge 1 through edge `RST_CYCLES`. It rises at edge `RST_CYCLES+1`.
- **Exit timing:**
  - `done` rises one edge after the exit-condition cycle.
  - `cycle_count` then equals the number of RUN cycles, including the exit cycle.
- **Outputs:** all are registered; no combinational path from input to output.

## Configuration
- **`CPU_RUN_SIG_EN` defined:**
  - `signature` updates on each captured write: `sig <= {sig[30:0], sig[31]} ^ zero_extend({ram_addr, ram_wdata})`.
  - `{ram_addr, ram_wdata}` is `ADDR_W + DATA_W` bits and must be ≤ 32.
- **`CPU_RUN_SIG_EN` undefined:** `signature` is tied to 0 and the accumulator is not built.

## Structure
- **Package `cpu_run_pkg`:**
  - state enum `run_state_t`
  - `SIG_W = 32`
  - signature-step function
- **Sub-module `cpu_run_sig`:** the signature accumulator, with inputs `clk`, `rst`, `clr`, `en`, `addr`, `data`. It is instantiated only under `CPU_RUN_SIG_EN`.

## Test plan
All scenarios use default parameters.
- **Reset:** hold `rst` = 1 → `cpu_rst_n` = 0, `busy` = 0, `done` = 0, every count = 0. Release `rst` → state stays IDLE.
- **Start sequence:** `start` pulse at edge 0 → `cpu_rst_n` low on edges 1–3 and high from edge 4; `busy` = 1 from edge 1.
- **Timeout:** no halt fetched → `done` = 1, `timeout` = 1, `cycle_count` = 70, `cpu_rst_n` back to 0.
- **Halt:** `ins` = 16'hF000 with `ins_valid` on the 10th RUN cycle → `done` next edge, `timeout` = 0, `cycle_count` = 10.
- **Write capture:** write (addr 3, data 8'h5A), then (addr 4, data 8'h01) → `wr_count` = 2, `last_wr_addr` = 4, `last_wr_data` = 8'h01.
  - With `CPU_RUN_SIG_EN`: `signature` = 32'h000002B5 (0x035A, then rotate to 0x06B4, then XOR 0x0401).
  - Without the macro: `signature` = 0.
- **Mid-run reset and restart:** assert `rst` on RUN cycle 5 → IDLE immediately, `cpu_rst_n` = 0. A new `start` then runs cleanly from `cycle_count` = 0.
